mlp_frame_sequencer: RTL and testbench

- Upstream/downstream wrapper for the combinational printed-MLP classifier core (9 features x 4 bit in, 2-bit class out).
- Accepts features serially, one 4-bit feature per valid/ready beat, and assembles the 36-bit input vector.
- Holds the vector stable on the core input for a programmable settle time, then samples the class and presents it on an output valid/ready handshake.
- Sits between the sensor/ADC front end and the result consumer.

---
 rtl/mlp_seq_pkg.sv | 16 +
 rtl/mlp_feat_packer.sv | 59 +++++
 rtl/mlp_frame_sequencer.sv | 112 +++++++++++
 tb/tb_mlp_frame_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// Shared types and default sizing for the printed-MLP frame sequencer.
package mlp_seq_pkg;

   localparam int N_FEAT     = 9;
   localparam int FEAT_W     = 4;
   localparam int CLS_W      = 2;
   localparam int SETTLE_CYC = 4;
   localparam int VEC_W      = N_FEAT * FEAT_W;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SETTLE  = 2'd1,
      OUT     = 2'd2
   } seq_state_t;

endpackage

// File: rtl/mlp_feat_packer.sv
// Frame assembler: packs serial feature beats into the classifier input
// vector and polices frame length. A long frame sets drop, and the rest of
// that frame is swallowed up to its feat_last beat without a second error.
module mlp_feat_packer #(
   parameter int N_FEAT = mlp_seq_pkg::N_FEAT,
   parameter int FEAT_W = mlp_seq_pkg::FEAT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       beat_xfer,
   input  logic [FEAT_W-1:0]          feat_data,
   input  logic                       feat_last,
   output logic [N_FEAT*FEAT_W-1:0]   mlp_inp,
   output logic                       frame_done,
   output logic                       frame_err
);

   localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_FEAT - 1);

   logic [CNT_W-1:0] feat_cnt;
   logic             drop;
   logic             at_max;

   assign at_max     = (feat_cnt == CNT_MAX);
   assign frame_done = beat_xfer && !drop && at_max && feat_last;

   // Slot write, feature counter, drop flag and the registered error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         feat_cnt  <= '0;
         drop      <= 1'b0;
         mlp_inp   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (beat_xfer) begin
            if (drop) begin
               if (feat_last) drop <= 1'b0;
            end else begin
               for (int k = 0; k < N_FEAT; k++) begin
                  if (feat_cnt == CNT_W'(k)) mlp_inp[k*FEAT_W +: FEAT_W] <= feat_data;
               end
               if (feat_last) begin
                  feat_cnt <= '0;
                  if (!at_max) frame_err <= 1'b1;
               end else if (at_max) begin
                  feat_cnt  <= '0;
                  drop      <= 1'b1;
                  frame_err <= 1'b1;
               end else begin
                  feat_cnt <= feat_cnt + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/mlp_frame_sequencer.sv
// Wrapper around the combinational printed-MLP classifier: collects a frame,
// holds it on the core for a settle time, then returns the class on a
// valid/ready handshake.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   COLLECT | accepting feature beats (incl. drain after a long frame)
//   SETTLE  | vector held on the core, settle_cnt counting down to 0
//   OUT     | class result presented, waiting for cls_ready
module mlp_frame_sequencer #(
   parameter int N_FEAT     = mlp_seq_pkg::N_FEAT,
   parameter int FEAT_W     = mlp_seq_pkg::FEAT_W,
   parameter int CLS_W      = mlp_seq_pkg::CLS_W,
   parameter int SETTLE_CYC = mlp_seq_pkg::SETTLE_CYC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       feat_valid,
   output logic                       feat_ready,
   input  logic [FEAT_W-1:0]          feat_data,
   input  logic                       feat_last,
   output logic [N_FEAT*FEAT_W-1:0]   mlp_inp,
   input  logic [CLS_W-1:0]           mlp_out,
   output logic                       cls_valid,
   input  logic                       cls_ready,
   output logic [CLS_W-1:0]           cls_data,
   output logic                       frame_err
);

   import mlp_seq_pkg::*;

   localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE_CYC - 1);

   seq_state_t       state, state_nxt;
   logic [SC_W-1:0]  settle_cnt, settle_nxt;
   logic             cls_valid_nxt;
   logic [CLS_W-1:0] cls_data_nxt;
   logic             beat_xfer;
   logic             frame_done;

   // Ready depends only on state (and is held low while in reset), so
   // cls_ready never reaches feat_ready combinationally.
   assign feat_ready = (state == COLLECT) && !rst;
   assign beat_xfer  = feat_valid && feat_ready;

   mlp_feat_packer #(
      .N_FEAT (N_FEAT),
      .FEAT_W (FEAT_W)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .beat_xfer  (beat_xfer),
      .feat_data  (feat_data),
      .feat_last  (feat_last),
      .mlp_inp    (mlp_inp),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   // State, settle counter and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= COLLECT;
         settle_cnt <= '0;
         cls_valid  <= 1'b0;
         cls_data   <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         cls_valid  <= cls_valid_nxt;
         cls_data   <= cls_data_nxt;
      end
   end

   // Next-state logic; cls_data only loads at the end of SETTLE, so it is
   // frozen for the whole OUT phase regardless of mlp_out.
   always_comb begin
      state_nxt     = state;
      settle_nxt    = settle_cnt;
      cls_valid_nxt = cls_valid;
      cls_data_nxt  = cls_data;
      case (state)
         COLLECT: begin
            if (frame_done) begin
               state_nxt  = SETTLE;
               settle_nxt = SETTLE_INIT;
            end
         end
         SETTLE: begin
            if (settle_cnt == '0) begin
               cls_data_nxt  = mlp_out;
               cls_valid_nxt = 1'b1;
               state_nxt     = OUT;
            end else begin
               settle_nxt = settle_cnt - SC_W'(1);
            end
         end
         OUT: begin
            if (cls_ready) begin
               cls_valid_nxt = 1'b0;
               state_nxt     = COLLECT;
            end
         end
         default: begin
            state_nxt     = COLLECT;
            cls_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mlp_frame_sequencer.sv
// Self-checking bench for mlp_frame_sequencer: directed table, hand-written
// corner sequences and randomized frames against a frame-level model.
module tb_mlp_frame_sequencer;

   localparam int N  = 9;
   localparam int FW = 4;
   localparam int SC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          feat_valid;
   logic          feat_ready;
   logic [FW-1:0] feat_data;
   logic          feat_last;
   logic [N*FW-1:0] mlp_inp;
   logic [1:0]    mlp_out;
   logic          cls_valid;
   logic          cls_ready;
   logic [1:0]    cls_data;
   logic          frame_err;
   logic [1:0]    stub_flip;

   // Classifier stub; stub_flip lets the bench wiggle mlp_out on demand.
   assign mlp_out = (mlp_inp[1:0] ^ mlp_inp[35:34]) ^ stub_flip;

   mlp_frame_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .feat_valid (feat_valid),
      .feat_ready (feat_ready),
      .feat_data  (feat_data),
      .feat_last  (feat_last),
      .mlp_inp    (mlp_inp),
      .mlp_out    (mlp_out),
      .cls_valid  (cls_valid),
      .cls_ready  (cls_ready),
      .cls_data   (cls_data),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Event monitors sampled away from the active edge.
   int   err_rises = 0, err_hi = 0, val_rises = 0;
   logic err_q = 1'b0, val_q = 1'b0;
   always @(negedge clk) begin
      if (frame_err === 1'b1) err_hi++;
      if (frame_err === 1'b1 && !err_q) err_rises++;
      if (cls_valid === 1'b1 && !val_q) val_rises++;
      err_q = (frame_err === 1'b1);
      val_q = (cls_valid === 1'b1);
   end

   logic [FW-1:0] fv [0:15];

   typedef struct {
      int          len;
      int          gap;
      bit          good;
      logic [35:0] vec;
      logic [1:0]  cls;
   } vec_t;

   vec_t tbl [0:8];

   task automatic send_beat(input logic [FW-1:0] d, input logic last);
      int g = 0;
      feat_valid = 1'b1;
      feat_data  = d;
      feat_last  = last;
      while (feat_ready !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) check("ready_timeout", 64'(feat_ready), 64'd1);
      @(negedge clk);
      feat_valid = 1'b0;
      feat_last  = 1'b0;
   endtask

   // gap: 0 back-to-back, 1 one idle cycle between beats, 2 random idles.
   task automatic run_frame(input int len, input int gap, input bit good,
                            input logic [35:0] exp_vec, input logic [1:0] exp_cls,
                            input int bp, input string tag);
      int e0, h0, v0, lat;
      logic [1:0] held;
      e0 = err_rises; h0 = err_hi; v0 = val_rises;
      for (int i = 0; i < len; i++) begin
         send_beat(fv[i], (i == len - 1));
         if (i < len - 1) begin
            if (gap == 1) @(negedge clk);
            else if (gap == 2 && ($urandom % 2) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
         end
      end
      if (good) begin
         lat = 0;
         while (cls_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
         end
         check({tag, " latency"}, 64'(lat), 64'(SC));
         check({tag, " cls_data"}, 64'(cls_data), 64'(exp_cls));
         check({tag, " mlp_inp"}, 64'(mlp_inp), 64'(exp_vec));
         check({tag, " ready_in_out"}, 64'(feat_ready), 64'd0);
         held = cls_data;
         for (int c = 0; c < bp; c++) begin
            stub_flip = 2'($urandom_range(1, 3));
            @(negedge clk);
            check({tag, " bp_valid"}, 64'(cls_valid), 64'd1);
            check({tag, " bp_data"}, 64'(cls_data), 64'(held));
            check({tag, " bp_ready"}, 64'(feat_ready), 64'd0);
         end
         stub_flip = 2'b00;
         cls_ready = 1'b1;
         @(negedge clk);
         cls_ready = 1'b0;
         check({tag, " valid_drop"}, 64'(cls_valid), 64'd0);
         check({tag, " ready_back"}, 64'(feat_ready), 64'd1);
      end else begin
         repeat (SC + 4) @(negedge clk);
      end
      #1;
      check({tag, " err_pulses"}, 64'(err_rises - e0), good ? 64'd0 : 64'd1);
      check({tag, " err_cycles"}, 64'(err_hi - h0), good ? 64'd0 : 64'd1);
      check({tag, " results"}, 64'(val_rises - v0), good ? 64'd1 : 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0] mvec;
      logic [1:0]  mcls;
      int          kind, len, v0;

      tbl[0] = '{9,  0, 1'b1, 36'h987654321, 2'b11};
      tbl[1] = '{9,  1, 1'b1, 36'h987654321, 2'b11};
      tbl[2] = '{5,  0, 1'b0, 36'h0, 2'b00};
      tbl[3] = '{9,  0, 1'b1, 36'h987654321, 2'b11};
      tbl[4] = '{11, 0, 1'b0, 36'h0, 2'b00};
      tbl[5] = '{9,  1, 1'b1, 36'h987654321, 2'b11};
      tbl[6] = '{1,  0, 1'b0, 36'h0, 2'b00};
      tbl[7] = '{10, 1, 1'b0, 36'h0, 2'b00};
      tbl[8] = '{9,  0, 1'b1, 36'h987654321, 2'b11};

      rst = 1'b1; feat_valid = 1'b0; feat_data = '0; feat_last = 1'b0;
      cls_ready = 1'b0; stub_flip = 2'b00;
      repeat (3) @(negedge clk);
      check("rst feat_ready", 64'(feat_ready), 64'd0);
      check("rst cls_valid", 64'(cls_valid), 64'd0);
      check("rst cls_data", 64'(cls_data), 64'd0);
      check("rst mlp_inp", 64'(mlp_inp), 64'd0);
      check("rst frame_err", 64'(frame_err), 64'd0);
      rst = 1'b0;
      #1;
      check("post_rst feat_ready", 64'(feat_ready), 64'd1);

      for (int i = 0; i < 16; i++) fv[i] = FW'(i + 1);
      for (int t = 0; t < 9; t++)
         run_frame(tbl[t].len, tbl[t].gap, tbl[t].good, tbl[t].vec, tbl[t].cls, 0,
                   $sformatf("tbl%0d", t));

      // Backpressure: result must hold for 10 cycles while mlp_out moves.
      run_frame(9, 0, 1'b1, 36'h987654321, 2'b11, 10, "backpressure");

      // Reset two cycles into SETTLE: everything clears at once, no result.
      for (int i = 0; i < N; i++) fv[i] = 4'hf;
      v0 = val_rises;
      for (int i = 0; i < N; i++) send_beat(fv[i], (i == N - 1));
      @(negedge clk);
      check("pre_rst mlp_inp", 64'(mlp_inp), 64'hfffffffff);
      rst = 1'b1;
      #1;
      check("mid_rst mlp_inp", 64'(mlp_inp), 64'd0);
      check("mid_rst cls_data", 64'(cls_data), 64'd0);
      check("mid_rst cls_valid", 64'(cls_valid), 64'd0);
      check("mid_rst feat_ready", 64'(feat_ready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_rst feat_ready", 64'(feat_ready), 64'd1);
      repeat (SC + 6) @(negedge clk);
      #1;
      check("rel_rst no_result", 64'(val_rises - v0), 64'd0);

      // Randomized frames against the frame-level model.
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 4);
         if (kind <= 2) len = N;
         else if (kind == 3) len = $urandom_range(1, N - 1);
         else len = $urandom_range(N + 1, 14);
         for (int i = 0; i < 16; i++) fv[i] = FW'($urandom);
         mvec = '0;
         for (int k = 0; k < N; k++) mvec = mvec | (36'(fv[k]) << (FW * k));
         mcls = mvec[1:0] ^ mvec[35:34];
         run_frame(len, 2, (len == N), mvec, mcls, $urandom_range(0, 3),
                   $sformatf("rnd%0d", f));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
